// File: rtl/mhp_tx.sv
// mhp_tx: transmit-side MHP framer.
// Serialises one frame per accepted request into the eth write FIFO:
//   7-byte header, payload (read from a 1-cycle-latency bram port),
//   zero pad up to MIN_BYTES, 16-bit additive checksum.
// Every byte is an EMIT sub-phase (waits for i_wready) followed by a GAP
// sub-phase, so o_wvalid is a single-cycle strobe followed by a low cycle.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_send                         start request (IDLE only)
//   i_dst_addr, i_src_addr         16-bit addresses
//   i_dir, i_type                  packed into the d_type header byte
//   i_len                          payload length, 0 .. 2**ADDR_W
//   o_pl_raddr / i_pl_rdata        payload bram read port
//   o_wdata, o_wvalid, i_wready    eth write FIFO interface
//   o_busy, o_done, o_err          status (done/err are 1-cycle pulses)
module mhp_tx #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MIN_BYTES = 46
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_send,
  input  logic [15:0]       i_dst_addr,
  input  logic [15:0]       i_src_addr,
  input  logic              i_dir,
  input  logic [6:0]        i_type,
  input  logic [ADDR_W:0]   i_len,
  output logic [ADDR_W-1:0] o_pl_raddr,
  input  logic [7:0]        i_pl_rdata,
  output logic [7:0]        o_wdata,
  input  logic              i_wready,
  output logic              o_wvalid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned LEN_W     = ADDR_W + 1;
  localparam int unsigned MAX_LEN   = 32'd1 << ADDR_W;
  localparam int unsigned HDR_BYTES = 7;
  localparam int unsigned OVH_BYTES = HDR_BYTES + 2;
  localparam int unsigned PAD_BASE  = (MIN_BYTES > OVH_BYTES) ? MIN_BYTES - OVH_BYTES : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAY,
    S_PAD,
    S_CSUM,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              emit_q, emit_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [15:0]       dst_q, src_q;
  logic [7:0]        dtype_q;
  logic [LEN_W-1:0]  len_q, pad_q;
  logic [15:0]       csum_q, csum_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              wvalid_q, wvalid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;

  logic              len_ok_c;
  logic              accept_c;
  logic [LEN_W-1:0]  pad_c;
  logic              byte_state_c;
  logic              fire_c;
  logic              last_c;
  logic [7:0]        cur_byte_c;
  logic [15:0]       len16_c;
  state_e            next_sec_c;

  // Request qualification and pad size, evaluated on the request inputs
  assign len_ok_c = (i_len <= LEN_W'(MAX_LEN));
  assign accept_c = (state_q == S_IDLE) && i_send && len_ok_c;
  assign pad_c    = (i_len < LEN_W'(PAD_BASE)) ? (LEN_W'(PAD_BASE) - i_len) : '0;

  // A byte transfers when an EMIT sub-phase sees the FIFO ready
  assign byte_state_c = (state_q == S_HDR) || (state_q == S_PAY) ||
                        (state_q == S_PAD) || (state_q == S_CSUM);
  assign fire_c       = byte_state_c && emit_q && i_wready;
  assign len16_c      = 16'(len_q);

  // Current byte of the active section
  always_comb begin
    cur_byte_c = 8'h00;
    case (state_q)
      S_HDR: begin
        case (idx_q[2:0])
          3'd0:    cur_byte_c = dst_q[15:8];
          3'd1:    cur_byte_c = dst_q[7:0];
          3'd2:    cur_byte_c = src_q[15:8];
          3'd3:    cur_byte_c = src_q[7:0];
          3'd4:    cur_byte_c = len16_c[15:8];
          3'd5:    cur_byte_c = len16_c[7:0];
          3'd6:    cur_byte_c = dtype_q;
          default: cur_byte_c = 8'h00;
        endcase
      end
      // bram output already reflects o_pl_raddr held since the preceding GAP
      S_PAY:   cur_byte_c = i_pl_rdata;
      S_CSUM:  cur_byte_c = idx_q[0] ? csum_q[7:0] : csum_q[15:8];
      default: cur_byte_c = 8'h00;
    endcase
  end

  // Last byte of the active section, and the section that follows it
  always_comb begin
    last_c     = 1'b0;
    next_sec_c = S_IDLE;
    case (state_q)
      S_HDR: begin
        last_c = (idx_q == LEN_W'(HDR_BYTES - 1));
        if (len_q != '0)      next_sec_c = S_PAY;
        else if (pad_q != '0) next_sec_c = S_PAD;
        else                  next_sec_c = S_CSUM;
      end
      S_PAY: begin
        last_c     = (idx_q == (len_q - LEN_W'(1)));
        next_sec_c = (pad_q != '0) ? S_PAD : S_CSUM;
      end
      S_PAD: begin
        last_c     = (idx_q == (pad_q - LEN_W'(1)));
        next_sec_c = S_CSUM;
      end
      S_CSUM: begin
        last_c     = (idx_q == LEN_W'(1));
        next_sec_c = S_DONE;
      end
      default: begin
        last_c     = 1'b0;
        next_sec_c = S_IDLE;
      end
    endcase
  end

  // State register plus all registered outputs and request latches
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      emit_q   <= 1'b0;
      idx_q    <= '0;
      dst_q    <= '0;
      src_q    <= '0;
      dtype_q  <= '0;
      len_q    <= '0;
      pad_q    <= '0;
      csum_q   <= '0;
      wdata_q  <= '0;
      wvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      raddr_q  <= '0;
    end else begin
      state_q  <= state_d;
      emit_q   <= emit_d;
      idx_q    <= idx_d;
      csum_q   <= csum_d;
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      raddr_q  <= raddr_d;
      if (accept_c) begin
        dst_q   <= i_dst_addr;
        src_q   <= i_src_addr;
        dtype_q <= {i_dir, i_type};
        len_q   <= i_len;
        pad_q   <= pad_c;
      end
    end
  end

  // Next-state: sequencing of sections and EMIT/GAP sub-phases
  always_comb begin
    state_d = state_q;
    emit_d  = emit_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d = S_HDR;
          emit_d  = 1'b1;
          idx_d   = '0;
        end
      end
      S_HDR, S_PAY, S_PAD, S_CSUM: begin
        if (emit_q) begin
          if (i_wready) emit_d = 1'b0;
        end else begin
          emit_d = 1'b1;
          if (last_c) begin
            idx_d   = '0;
            state_d = next_sec_c;
          end else begin
            idx_d = idx_q + LEN_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        emit_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        emit_d  = 1'b0;
        idx_d   = '0;
      end
    endcase
  end

  // Output/datapath next values
  always_comb begin
    wvalid_d = fire_c;
    wdata_d  = fire_c ? cur_byte_c : wdata_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    csum_d   = csum_q;
    raddr_d  = raddr_q;
    case (state_q)
      S_IDLE: begin
        wdata_d = 8'h00;
        raddr_d = '0;
        busy_d  = accept_c;
        err_d   = i_send && !len_ok_c;
        if (accept_c) csum_d = '0;
      end
      S_HDR, S_PAY, S_PAD, S_CSUM: begin
        if (fire_c && ((state_q == S_HDR) || (state_q == S_PAY))) begin
          csum_d = csum_q + 16'(cur_byte_c);
        end
        // Advance the read address during the GAP that precedes the next payload byte
        if (fire_c && (state_q == S_PAY)) begin
          raddr_d = last_c ? '0 : ADDR_W'(idx_q + LEN_W'(1));
        end
        if ((state_q == S_CSUM) && !emit_q && last_c) begin
          done_d  = 1'b1;
          wdata_d = 8'h00;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        wdata_d = 8'h00;
        raddr_d = '0;
      end
      default: begin
        busy_d  = 1'b0;
        wdata_d = 8'h00;
        raddr_d = '0;
      end
    endcase
  end

  assign o_pl_raddr = raddr_q;
  assign o_wdata    = wdata_q;
  assign o_wvalid   = wvalid_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_mhp_tx.sv
// tb_mhp_tx: self-checking bench for mhp_tx with a queue-based frame model.
module tb_mhp_tx;

  localparam int unsigned ADDR_W = 10;

  typedef logic [7:0] bq_t[$];

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_send;
  logic [15:0]       i_dst_addr;
  logic [15:0]       i_src_addr;
  logic              i_dir;
  logic [6:0]        i_type;
  logic [ADDR_W:0]   i_len;
  logic [ADDR_W-1:0] o_pl_raddr;
  logic [7:0]        pl_rdata;
  logic [7:0]        o_wdata;
  logic              i_wready = 1'b1;
  logic              o_wvalid;
  logic              o_busy;
  logic              o_done;
  logic              o_err;

  always #5 clk = ~clk;

  mhp_tx #(.ADDR_W(ADDR_W), .MIN_BYTES(46)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_send     (i_send),
    .i_dst_addr (i_dst_addr),
    .i_src_addr (i_src_addr),
    .i_dir      (i_dir),
    .i_type     (i_type),
    .i_len      (i_len),
    .o_pl_raddr (o_pl_raddr),
    .i_pl_rdata (pl_rdata),
    .o_wdata    (o_wdata),
    .i_wready   (i_wready),
    .o_wvalid   (o_wvalid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_err      (o_err)
  );

  // Payload buffer with 1-cycle read latency
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) pl_rdata <= mem[o_pl_raddr];

  int   n_chk = 0;
  int   n_pass = 0;
  int   n_strobe = 0;
  int   n_done = 0;
  int   n_err = 0;
  bq_t  exp_q;
  int   exp_len, base_done, base_str;
  bit   rand_ready = 1'b0;
  int   cyc = 0;
  int   stall_until = -1;
  logic prev_valid = 1'b0;
  logic prev_ready = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference frame: header, payload, zero pad, 16-bit sum of header+payload
  function automatic bq_t build_frame(input logic [15:0] dst, input logic [15:0] src,
                                      input logic dir, input logic [6:0] typ, input int len);
    bq_t f;
    int  sum;
    f.push_back(dst[15:8]);
    f.push_back(dst[7:0]);
    f.push_back(src[15:8]);
    f.push_back(src[7:0]);
    f.push_back(8'(len >> 8));
    f.push_back(8'(len));
    f.push_back({dir, typ});
    for (int k = 0; k < len; k++) f.push_back(mem[k]);
    sum = 0;
    foreach (f[i]) sum += int'(f[i]);
    for (int i = 0; i < 46 - 9 - len; i++) f.push_back(8'h00);
    f.push_back(8'(sum >> 8));
    f.push_back(8'(sum));
    return f;
  endfunction

  // FIFO readiness: random, forced low during a stall window, else always ready
  always @(posedge clk) begin
    #1;
    cyc++;
    if (cyc <= stall_until) i_wready = 1'b0;
    else if (rand_ready)    i_wready = ($urandom_range(0, 2) != 0);
    else                    i_wready = 1'b1;
  end

  // Compare process: every strobe against the model queue, plus protocol rules
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (o_wvalid) begin
        check("gap_before_strobe", 32'(prev_valid), 0);
        check("ready_before_strobe", 32'(prev_ready), 1);
        check("busy_during_strobe", 32'(o_busy), 1);
        check("strobe_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("wdata", 32'(o_wdata), 32'(exp_q.pop_front()));
        n_strobe++;
      end else if (!o_busy) begin
        check("idle_wdata", 32'(o_wdata), 0);
        check("idle_raddr", 32'(o_pl_raddr), 0);
      end
      if (o_done) begin
        check("done_busy", 32'(o_busy), 1);
        check("done_queue_empty", 32'(exp_q.size()), 0);
        n_done++;
      end
      if (o_err) n_err++;
      prev_valid = o_wvalid;
      prev_ready = i_wready;
    end
  end

  task automatic send_req(input logic [15:0] dst, input logic [15:0] src,
                          input logic dir, input logic [6:0] typ, input int len);
    @(posedge clk); #1;
    i_dst_addr = dst;
    i_src_addr = src;
    i_dir      = dir;
    i_type     = typ;
    i_len      = (ADDR_W+1)'(len);
    i_send     = 1'b1;
    @(posedge clk); #1;
    i_send     = 1'b0;
  endtask

  task automatic start_frame(input logic [15:0] dst, input logic [15:0] src,
                             input logic dir, input logic [6:0] typ, input int len);
    exp_q     = build_frame(dst, src, dir, typ, len);
    exp_len   = exp_q.size();
    base_done = n_done;
    base_str  = n_strobe;
    send_req(dst, src, dir, typ, len);
    check("busy_after_accept", 32'(o_busy), 1);
  endtask

  task automatic finish_frame();
    int t = 0;
    while (n_done == base_done && t < 20000) begin
      @(posedge clk);
      t++;
    end
    check("frame_done_seen", 32'(n_done - base_done), 1);
    repeat (4) @(posedge clk);
    check("strobe_count", 32'(n_strobe - base_str), 32'(exp_len));
    check("queue_drained", 32'(exp_q.size()), 0);
    check("single_done", 32'(n_done - base_done), 1);
    check("idle_busy", 32'(o_busy), 0);
  endtask

  task automatic run_frame(input logic [15:0] dst, input logic [15:0] src,
                           input logic dir, input logic [6:0] typ, input int len);
    start_frame(dst, src, dir, typ, len);
    finish_frame();
  endtask

  task automatic wait_strobes(input int n);
    int t = 0;
    while ((n_strobe - base_str) < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("strobes_reached", 32'(n_strobe - base_str), 32'(n));
  endtask

  task automatic load_t1();
    mem[0] = 8'hAA; mem[1] = 8'hBB; mem[2] = 8'hCC; mem[3] = 8'hDD;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wvalid"}, 32'(o_wvalid), 0);
    check({tag, "_wdata"},  32'(o_wdata), 0);
    check({tag, "_busy"},   32'(o_busy), 0);
    check({tag, "_done"},   32'(o_done), 0);
    check({tag, "_err"},    32'(o_err), 0);
    check({tag, "_raddr"},  32'(o_pl_raddr), 0);
  endtask

  initial begin
    bq_t f;
    int  len, base_e, r;
    rst_n = 1'b0; i_send = 1'b0;
    i_dst_addr = '0; i_src_addr = '0; i_dir = 1'b0; i_type = '0; i_len = '0;
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 8'h00;
    #2;
    check_all_zero("reset");
    #10 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Hand-computed frames pin the model
    load_t1();
    f = build_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 4);
    check("pin1_size", 32'(f.size()), 46);
    check("pin1_dtype", 32'(f[6]), 32'h85);
    check("pin1_pad", 32'(f[11]), 0);
    check("pin1_csum", 32'({f[44], f[45]}), 32'h03DE);
    f = build_frame(16'hFFFF, 16'h0000, 1'b0, 7'h00, 0);
    check("pin2_size", 32'(f.size()), 46);
    check("pin2_csum", 32'({f[44], f[45]}), 32'h01FE);

    // Frame with pad
    run_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 4);
    // Empty payload
    run_frame(16'hFFFF, 16'h0000, 1'b0, 7'h00, 0);

    // No pad: payload[k] = k
    for (int k = 0; k < 100; k++) mem[k] = 8'(k);
    f = build_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 100);
    check("pin3_size", 32'(f.size()), 109);
    check("pin3_csum", 32'({f[107], f[108]}), 32'h1486);
    run_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 100);

    // Backpressure at payload byte 2 plus an ignored mid-frame request
    load_t1();
    start_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 4);
    wait_strobes(9);
    stall_until = cyc + 20;
    repeat (5) @(posedge clk);
    send_req(16'hBEEF, 16'hCAFE, 1'b0, 7'h11, 5);
    repeat (13) @(posedge clk);
    check("no_strobe_in_stall", 32'(n_strobe - base_str), 9);
    finish_frame();

    // Rejected length
    base_e = n_err;
    base_str = n_strobe;
    @(posedge clk); #1;
    i_len = (ADDR_W+1)'((1 << ADDR_W) + 1);
    i_send = 1'b1;
    @(posedge clk); #1;
    i_send = 1'b0;
    check("err_pulse", 32'(o_err), 1);
    check("err_busy", 32'(o_busy), 0);
    @(posedge clk); #1;
    check("err_cleared", 32'(o_err), 0);
    repeat (10) @(posedge clk);
    check("err_count", 32'(n_err - base_e), 1);
    check("err_no_strobes", 32'(n_strobe - base_str), 0);
    check("err_idle", 32'(o_busy), 0);

    // Reset at header byte 3, then the same frame again
    start_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 4);
    wait_strobes(3);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_frame(16'h1234, 16'h0001, 1'b1, 7'h05, 4);

    // Randomised readiness from here on
    rand_ready = 1'b1;
    // Max length, checksum wraps
    for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 8'($urandom);
    run_frame(16'($urandom), 16'($urandom), 1'($urandom), 7'($urandom), 1 << ADDR_W);
    for (int k = 0; k < 300; k++) mem[k] = 8'hFF;
    run_frame(16'hFFFF, 16'hFFFF, 1'b1, 7'h7F, 300);

    // Random frames around the pad boundary and beyond
    for (int n = 0; n < 20; n++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       len = int'($urandom_range(0, 3));
        1:       len = int'($urandom_range(35, 39));
        default: len = int'($urandom_range(0, 150));
      endcase
      for (int k = 0; k < len; k++) mem[k] = 8'($urandom);
      run_frame(16'($urandom), 16'($urandom), 1'($urandom), 7'($urandom), len);
    end

    rand_ready = 1'b0;
    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
